// File: rtl/common_params.sv
// Shared widths and encodings for the EX-stage divider.
package common_params;

    localparam int BITS    = 32;
    localparam int CNT_W   = $clog2(BITS) + 1;
    localparam int DIV_LAT = BITS + 2;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic logic is_signed_op(input div_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input div_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_signfix.sv
// Sign handling around the unsigned core: operand magnitudes at accept,
// conditional negation of quotient/remainder in FIX.
module div_signfix
    import common_params::*;
#(
    parameter int W = BITS
) (
    input  logic         i_signed,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    input  logic         i_neg_q,
    input  logic         i_neg_r,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_rem,
    output logic         o_sign_dividend,
    output logic         o_sign_divisor,
    output logic [W-1:0] o_mag_dividend,
    output logic [W-1:0] o_mag_divisor,
    output logic [W-1:0] o_quo,
    output logic [W-1:0] o_rem
);

    assign o_sign_dividend = i_signed & i_dividend[W-1];
    assign o_sign_divisor  = i_signed & i_divisor[W-1];

    // The most negative value maps onto itself, which reads correctly as unsigned.
    assign o_mag_dividend = o_sign_dividend ? (~i_dividend + 1'b1) : i_dividend;
    assign o_mag_divisor  = o_sign_divisor  ? (~i_divisor  + 1'b1) : i_divisor;

    assign o_quo = i_neg_q ? (~i_quo + 1'b1) : i_quo;
    assign o_rem = i_neg_r ? (~i_rem + 1'b1) : i_rem;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a one-cycle
// path for divide-by-zero and signed overflow.
module div_unit
    import common_params::*;
#(
    parameter int BITS  = common_params::BITS,
    parameter int CNT_W = $clog2(BITS) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  div_t            DIV_OP,
    input  logic [BITS-1:0] Dividend,
    input  logic [BITS-1:0] Divisor,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] Div_Out
);

    localparam logic [BITS-1:0] SMIN = {1'b1, {(BITS-1){1'b0}}};

    state_t          r_state, w_next;
    div_t            r_op;
    logic            r_neg_q, r_neg_r;
    logic [BITS-1:0] r_rem, r_quo, r_dvsr, r_out;
    logic [CNT_W-1:0] r_cnt;

    logic            w_accept, w_signed, w_div0, w_ovf, w_special;
    logic [BITS-1:0] w_special_out;
    logic            w_sign_dvd, w_sign_dvs;
    logic [BITS-1:0] w_mag_dvd, w_mag_dvs, w_quo_fix, w_rem_fix;
    logic [BITS:0]   w_shift, w_diff;
    logic            w_fits;

    assign w_accept  = start & ~flush & ((r_state == IDLE) | (r_state == DONE));
    assign w_signed  = is_signed_op(DIV_OP);
    assign w_div0    = (Divisor == '0);
    assign w_ovf     = w_signed & (Dividend == SMIN) & (Divisor == '1);
    assign w_special = w_div0 | w_ovf;

    always_comb begin
        if (w_div0)
            w_special_out = is_rem_op(DIV_OP) ? Dividend : '1;
        else
            w_special_out = is_rem_op(DIV_OP) ? '0 : SMIN;
    end

    div_signfix #(.W(BITS)) u_signfix (
        .i_signed        (w_signed),
        .i_dividend      (Dividend),
        .i_divisor       (Divisor),
        .i_neg_q         (r_neg_q),
        .i_neg_r         (r_neg_r),
        .i_quo           (r_quo),
        .i_rem           (r_rem),
        .o_sign_dividend (w_sign_dvd),
        .o_sign_divisor  (w_sign_dvs),
        .o_mag_dividend  (w_mag_dvd),
        .o_mag_divisor   (w_mag_dvs),
        .o_quo           (w_quo_fix),
        .o_rem           (w_rem_fix)
    );

    // One extra bit on the trial subtract: its MSB is the borrow.
    assign w_shift = {r_rem, r_quo[BITS-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};
    assign w_fits  = ~w_diff[BITS];

    // NOTE: default first so every path assigns w_next and no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = w_special ? DONE : CALC;
            CALC: if (r_cnt == CNT_W'(BITS - 1)) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: begin
                if (w_accept) w_next = w_special ? DONE : CALC;
                else          w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= DIV;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= DIV_OP;
                r_neg_q <= (DIV_OP == DIV) & (w_sign_dvd ^ w_sign_dvs);
                r_neg_r <= (DIV_OP == REM) & w_sign_dvd;
                r_quo   <= w_mag_dvd;
                r_dvsr  <= w_mag_dvs;
                r_rem   <= '0;
                r_cnt   <= '0;
                if (w_special) r_out <= w_special_out;
            end else if (!flush) begin
                if (r_state == CALC) begin
                    r_rem <= w_fits ? w_diff[BITS-1:0] : w_shift[BITS-1:0];
                    r_quo <= {r_quo[BITS-2:0], w_fits};
                    r_cnt <= r_cnt + 1'b1;
                end else if (r_state == FIX) begin
                    r_out <= is_rem_op(r_op) ? w_rem_fix : w_quo_fix;
                end
            end
        end
    end

    // Stall request depends on state only, keeping start off the stall path.
    assign busy    = (r_state == CALC) | (r_state == FIX);
    assign done    = (r_state == DONE);
    assign Div_Out = r_out;

endmodule
